// File: rtl/aes_data_out_drain.sv
// aes_data_out_drain
// Captures finished 128-bit AES output blocks, strobes the core's DATA_OUT
// registers to release them, buffers the blocks in a small FIFO and streams
// them out as four 32-bit words per block over valid/ready with a last flag.
module aes_data_out_drain #(
    parameter int Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       out_valid_i,
    input  logic [127:0]               data_out_i,
    output logic [3:0]                 data_out_re_o,
    output logic [31:0]                tdata_o,
    output logic                       tvalid_o,
    output logic                       tlast_o,
    input  logic                       tready_i,
    output logic [$clog2(Depth+1)-1:0] level_o,
    output logic                       full_o
);

    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int LW = $clog2(Depth + 1);

    // WAIT holds off a second capture until the core's status drops, since
    // output_valid lags the read strobes by a cycle.
    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [127:0]    mem [Depth];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [1:0]      wcnt_q;
    logic [LW-1:0]   level_q;
    logic [127:0]    head_block;
    logic            push, pop, xfer;

    // Status outputs come straight from the block counter; full is judged on
    // the registered level, so a push at full is refused even during a pop.
    assign level_o  = level_q;
    assign full_o   = (level_q == LW'(Depth));
    assign tvalid_o = (level_q != '0);
    assign xfer     = tvalid_o && tready_i;
    assign pop      = xfer && (wcnt_q == 2'd3);

    // Stream word selection; data is forced to zero while nothing is held so
    // the unreset storage never leaks onto the bus.
    assign head_block = mem[rd_ptr_q];
    assign tdata_o    = tvalid_o ? head_block[{wcnt_q, 5'd0} +: 32] : 32'h0;
    assign tlast_o    = tvalid_o && (wcnt_q == 2'd3);

    // Capture FSM next-state and strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d       = state_q;
        push          = 1'b0;
        data_out_re_o = 4'b0000;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // rst_ni gates the strobe so it stays low while reset is held.
                    if (rst_ni && out_valid_i && !full_o) begin
                        push          = 1'b1;
                        data_out_re_o = 4'b1111;
                        state_d       = WAIT;
                    end
                end
                WAIT: begin
                    if (!out_valid_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state: FSM, pointers, word counter and block level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wcnt_q   <= 2'd0;
            level_q  <= '0;
        end else if (clear_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wcnt_q   <= 2'd0;
            level_q  <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (xfer) wcnt_q   <= wcnt_q + 2'd1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Block storage written on capture.
    always_ff @(posedge clk_i) begin
        // NOTE: the data array has no reset; validity is tracked entirely by
        // the reset control state, so clearing the payload buys nothing.
        if (push) mem[wr_ptr_q] <= data_out_i;
    end

endmodule
